sm4_round_iter: RTL and testbench
=================================

# sm4_round_iter

Iterative SM4 round engine that consumes a 128-bit block and 32 externally stored round keys and produces the 128-bit cipher or plain text. It is the direct consumer of the registered 8-bit S-box: each round's τ substitution runs through four S-box instances, and this block supplies their inputs and applies the L transform to their registered outputs. It sits between the host block interface and the round-key store.

## Interface
- No parameters; round count fixed at 32.
- CLK_i  in  1  single clock, all state on rising edge
- RST_i  in  1  asynchronous, active-high reset
- DIN_VALID_i  in  1  input block valid
- DIN_READY_o  out  1  engine idle, input accepted on VALID&&READY
- DIN_i  in  128  input block, [127:96]=X0 … [31:0]=X3
- DEC_i  in  1  sampled with DIN_i; 1 = decrypt
- RK_IDX_o  out  5  round-key index requested
- RK_i  in  32  round key at RK_IDX_o, combinational from key store
- DOUT_VALID_o  out  1  result valid, held until taken
- DOUT_READY_i  in  1  consumer ready
- DOUT_o  out  128  result, {X35,X34,X33,X32}
- BUSY_o  out  1  high from acceptance until output handshake

## Operation
- States: IDLE, SUB, LIN, DONE.
- IDLE: DIN_READY_o=1. On VALID&&READY, load X0..X3 from DIN_i, latch DEC, clear round counter, go to SUB.
- SUB: drive S-box bytes of X1^X2^X3^RK_i; S-box registers them at the edge; go to LIN.
- LIN: B = registered S-box word; T = B^rol(B,2)^rol(B,10)^rol(B,18)^rol(B,24); shift {X0,X1,X2,X3} ← {X1,X2,X3,X0^T}; counter+1. If the counter was 31, go to DONE; otherwise go to SUB.
- DONE: DOUT_VALID_o=1, DOUT_o = reversed words. On DOUT_READY_i, go to IDLE.
- RK_IDX_o = counter for encrypt, 31−counter for decrypt. It is stable for the whole round. RK_i is used only in SUB.
- DIN_VALID_i is ignored outside IDLE. DOUT_o and DOUT_VALID_o are held stable while DONE && !DOUT_READY_i.
- All arithmetic is 32-bit XOR and rotate-left. The counter is 5 bits with no wrap: exit is at 31.

## Timing
- Reset values: DIN_READY_o=1, DOUT_VALID_o=0, DOUT_o=0, RK_IDX_o=0, BUSY_o=0. The state goes to IDLE and X and the counter clear. The S-box output is unreset and is never consumed before a SUB cycle.
- Latency: acceptance at edge E; DOUT_VALID_o rises after edge E+64 (32 rounds × 2 cycles).
- Minimum block period: 66 cycles (accept, 64 round cycles, output handshake cycle).
- DIN_READY_o is low from E until the cycle after the output handshake. No new block is accepted in the same cycle as the output handshake.
- Reset mid-operation aborts immediately with no output produced.

## Configuration
- SM4_DEC_EN defined: DEC_i is honoured and selects the reversed key order.
- SM4_DEC_EN undefined: DEC_i is ignored and RK_IDX_o = counter always (encrypt only). The latched DEC flag and the index subtractor are removed.

## Structure
- Shared package sm4_pkg holds:
  - the state enum (IDLE/SUB/LIN/DONE);
  - SM4_ROUNDS=32;
  - L rotation constants 2/10/18/24;
  - a function for L.
- Sub-module sm4_tau: a 32-bit registered τ built from four S-box instances, one per byte, input X_i[31:0], output Y_o[31:0], latency 1.

## Test plan
- Standard vector: key 0123456789ABCDEFFEDCBA9876543210 (model supplies rk0=F12186F9 … rk31=9124A012), encrypt DIN 0123456789ABCDEFFEDCBA9876543210 → DOUT 681EDF34D206965E86B3E94F536E4246, DOUT_VALID_o 64 cycles after acceptance.
- With SM4_DEC_EN: DEC_i=1, DIN 681EDF34D206965E86B3E94F536E4246 → DOUT 0123456789ABCDEFFEDCBA9876543210; RK_IDX_o sequence 31,30…0. Without the macro, DEC_i=1 still yields 681EDF34D206965E86B3E94F536E4246.
- Backpressure: DOUT_READY_i low for 10 cycles in DONE → DOUT_o stable and DIN_READY_o low throughout; DIN_VALID_i pulses are ignored.
- Back-to-back: two blocks with VALID held high → second accepted exactly 66 cycles after the first; both results correct.
- Reset at round 15 (RST_i pulsed mid-SUB) → outputs return to reset values asynchronously. A following standard vector still produces 681EDF34D206965E86B3E94F536E4246.
- Ordering: RK_IDX_o equals the round number on every SUB cycle for encrypt, checked against the scoreboard for all 32 rounds.

Source files
------------

// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: FSM states, round count, L-transform rotations and helpers.
package sm4_pkg;

  localparam int unsigned SM4_ROUNDS = 32;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned IDX_W      = 5;

  localparam int unsigned L_ROT0 = 2;
  localparam int unsigned L_ROT1 = 10;
  localparam int unsigned L_ROT2 = 18;
  localparam int unsigned L_ROT3 = 24;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SUB  = 2'd1,
    ST_LIN  = 2'd2,
    ST_DONE = 2'd3
  } sm4_state_t;

  function automatic logic [WORD_W-1:0] sm4_rol(input logic [WORD_W-1:0] v,
                                                input int unsigned n);
    return (v << n) | (v >> (WORD_W - n));
  endfunction

  // Linear diffusion applied to the substituted word of each round.
  function automatic logic [WORD_W-1:0] sm4_l(input logic [WORD_W-1:0] b);
    return b ^ sm4_rol(b, L_ROT0) ^ sm4_rol(b, L_ROT1)
             ^ sm4_rol(b, L_ROT2) ^ sm4_rol(b, L_ROT3);
  endfunction

endpackage

// File: rtl/sm4_round_iter_if.sv
// Host block handshake and round-key store port of the SM4 round engine.
interface sm4_round_iter_if;
  logic         DIN_VALID_i;
  logic         DIN_READY_o;
  logic [127:0] DIN_i;
  logic         DEC_i;
  logic [4:0]   RK_IDX_o;
  logic [31:0]  RK_i;
  logic         DOUT_VALID_o;
  logic         DOUT_READY_i;
  logic [127:0] DOUT_o;
  logic         BUSY_o;

  modport master (
    output DIN_VALID_i, DIN_i, DEC_i, RK_i, DOUT_READY_i,
    input  DIN_READY_o, RK_IDX_o, DOUT_VALID_o, DOUT_o, BUSY_o
  );

  modport slave (
    input  DIN_VALID_i, DIN_i, DEC_i, RK_i, DOUT_READY_i,
    output DIN_READY_o, RK_IDX_o, DOUT_VALID_o, DOUT_o, BUSY_o
  );
endinterface

// File: rtl/sm4_round_iter_tau.sv
// Registered SM4 tau: four registered byte S-boxes, one cycle latency, no reset.
module sm4_sbox (
  input  logic       CLK_i,
  input  logic [7:0] A_i,
  output logic [7:0] Q_o
);
  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  logic [7:0] r_q;

  always_ff @(posedge CLK_i) begin
    r_q <= SBOX[A_i];
  end

  assign Q_o = r_q;
endmodule

module sm4_tau (
  input  logic        CLK_i,
  input  logic [31:0] X_i,
  output logic [31:0] Y_o
);
  for (genvar g = 0; g < 4; g++) begin : g_byte
    sm4_sbox u_sbox (
      .CLK_i (CLK_i),
      .A_i   (X_i[8*g +: 8]),
      .Q_o   (Y_o[8*g +: 8])
    );
  end
endmodule

// File: rtl/sm4_round_iter.sv
// Iterative SM4 round engine, two cycles per round (S-box, then L and word shift).
// Optional feature macro SM4_DEC_EN: honour DEC_i and walk the round keys in reverse.
module sm4_round_iter
  import sm4_pkg::*;
(
  input  logic              CLK_i,
  input  logic              RST_i,
  sm4_round_iter_if.slave   bus
);

  sm4_state_t         r_state;
  logic [WORD_W-1:0]  r_x0, r_x1, r_x2, r_x3;
  logic [IDX_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_rk_idx;
  logic               r_din_ready;
  logic               r_dout_valid;
  logic [BLOCK_W-1:0] r_dout;
  logic               r_busy;

  logic [WORD_W-1:0]  w_tau_in;
  logic [WORD_W-1:0]  w_tau_out;
  logic [WORD_W-1:0]  w_new_word;
  logic [IDX_W-1:0]   w_cnt_inc;
  logic [IDX_W-1:0]   w_idx_next;
  logic [IDX_W-1:0]   w_idx_load;
  logic               w_last;

  assign w_tau_in   = r_x1 ^ r_x2 ^ r_x3 ^ bus.RK_i;
  assign w_new_word = r_x0 ^ sm4_l(w_tau_out);
  assign w_cnt_inc  = r_cnt + IDX_W'(1);
  assign w_last     = (r_cnt == IDX_W'(SM4_ROUNDS - 1));

`ifdef SM4_DEC_EN
  logic r_dec;

  // Direction is captured with the block so DEC_i may change while busy.
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      r_dec <= 1'b0;
    end else if (r_state == ST_IDLE && bus.DIN_VALID_i) begin
      r_dec <= bus.DEC_i;
    end
  end

  assign w_idx_next = r_dec ? (IDX_W'(SM4_ROUNDS - 1) - w_cnt_inc) : w_cnt_inc;
  assign w_idx_load = bus.DEC_i ? IDX_W'(SM4_ROUNDS - 1) : IDX_W'(0);
`else
  assign w_idx_next = w_cnt_inc;
  assign w_idx_load = IDX_W'(0);
`endif

  sm4_tau u_tau (
    .CLK_i (CLK_i),
    .X_i   (w_tau_in),
    .Y_o   (w_tau_out)
  );

  // Round sequencer; every output is a register updated here.
  always_ff @(posedge CLK_i or posedge RST_i) begin
    if (RST_i) begin
      r_state      <= ST_IDLE;
      r_x0         <= '0;
      r_x1         <= '0;
      r_x2         <= '0;
      r_x3         <= '0;
      r_cnt        <= '0;
      r_rk_idx     <= '0;
      r_din_ready  <= 1'b1;
      r_dout_valid <= 1'b0;
      r_dout       <= '0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.DIN_VALID_i) begin
            r_x0        <= bus.DIN_i[127:96];
            r_x1        <= bus.DIN_i[95:64];
            r_x2        <= bus.DIN_i[63:32];
            r_x3        <= bus.DIN_i[31:0];
            r_cnt       <= '0;
            r_rk_idx    <= w_idx_load;
            r_din_ready <= 1'b0;
            r_busy      <= 1'b1;
            r_state     <= ST_SUB;
          end
        end
        ST_SUB: begin
          r_state <= ST_LIN;
        end
        ST_LIN: begin
          r_x0 <= r_x1;
          r_x1 <= r_x2;
          r_x2 <= r_x3;
          r_x3 <= w_new_word;
          if (w_last) begin
            // Counter and key index hold at the final round; no wrap.
            r_dout       <= {w_new_word, r_x3, r_x2, r_x1};
            r_dout_valid <= 1'b1;
            r_state      <= ST_DONE;
          end else begin
            r_cnt    <= w_cnt_inc;
            r_rk_idx <= w_idx_next;
            r_state  <= ST_SUB;
          end
        end
        ST_DONE: begin
          if (bus.DOUT_READY_i) begin
            r_dout_valid <= 1'b0;
            r_din_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.DIN_READY_o  = r_din_ready;
  assign bus.RK_IDX_o     = r_rk_idx;
  assign bus.DOUT_VALID_o = r_dout_valid;
  assign bus.DOUT_o       = r_dout;
  assign bus.BUSY_o       = r_busy;

endmodule

// File: tb/tb_sm4_round_iter.sv
// Self-checking bench for sm4_round_iter: standard vectors, random blocks vs. a word-queue SM4 model.
module tb_sm4_round_iter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sm4_round_iter_if bus ();

  sm4_round_iter u_dut (
    .CLK_i (clk),
    .RST_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] STD_KEY = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] STD_PT  = 128'h0123456789ABCDEFFEDCBA9876543210;
  localparam logic [127:0] STD_CT  = 128'h681EDF34D206965E86B3E94F536E4246;

  localparam logic [7:0] SB [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

  // Round-key store seen by the DUT.
  logic [31:0] ks [32];
  assign bus.RK_i = ks[bus.RK_IDX_o];

  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] w);
    return {SB[w[31:24]], SB[w[23:16]], SB[w[15:8]], SB[w[7:0]]};
  endfunction

  function automatic logic [31:0] l_data(input logic [31:0] b);
    return b ^ rol(b, 2) ^ rol(b, 10) ^ rol(b, 18) ^ rol(b, 24);
  endfunction

  function automatic logic [31:0] l_key(input logic [31:0] b);
    return b ^ rol(b, 13) ^ rol(b, 23);
  endfunction

  task automatic set_key(input logic [127:0] mk);
    logic [31:0] k [36];
    logic [31:0] fk [4];
    logic [31:0] ck;
    fk = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
    for (int i = 0; i < 4; i++) k[i] = mk[127 - 32*i -: 32] ^ fk[i];
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31 - 8*j -: 8] = 8'(((4*i + j) * 7) % 256);
      k[i+4] = k[i] ^ l_key(tau(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck));
      ks[i]  = k[i+4];
    end
  endtask

  // Reference cipher over a sliding window of four words, keys taken from ks.
  function automatic logic [127:0] model(input logic [127:0] din, input logic dec);
    logic [31:0] x [$];
    logic [31:0] rk;
    x = '{din[127:96], din[95:64], din[63:32], din[31:0]};
    for (int r = 0; r < 32; r++) begin
      rk = dec ? ks[31 - r] : ks[r];
      x.push_back(x[0] ^ l_data(tau(x[1] ^ x[2] ^ x[3] ^ rk)));
      void'(x.pop_front());
    end
    return {x[3], x[2], x[1], x[0]};
  endfunction

  function automatic logic eff_dec(input logic dec);
`ifdef SM4_DEC_EN
    return dec;
`else
    return 1'b0 & dec;
`endif
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, "_din_ready"},  128'(bus.DIN_READY_o),  128'(1'b1));
    chk({nm, "_dout_valid"}, 128'(bus.DOUT_VALID_o), 128'(1'b0));
    chk({nm, "_dout"},       bus.DOUT_o,             128'(0));
    chk({nm, "_rk_idx"},     128'(bus.RK_IDX_o),     128'(0));
    chk({nm, "_busy"},       128'(bus.BUSY_o),       128'(1'b0));
  endtask

  // Offers a block, waits for acceptance; returns 0 on timeout.
  task automatic offer(input logic [127:0] din, input logic dec, output bit ok);
    int n;
    @(posedge clk); #1;
    bus.DIN_VALID_i = 1'b1;
    bus.DIN_i       = din;
    bus.DEC_i       = dec;
    n = 0;
    while (!bus.DIN_READY_o && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    ok = bus.DIN_READY_o;
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout got=%0d exp=<200", n);
      bus.DIN_VALID_i = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.DIN_VALID_i = 1'b0;
    bus.DIN_i       = 128'($urandom);
  endtask

  task automatic run_block(input string nm, input logic [127:0] din, input logic dec,
                           input logic [127:0] exp, input int bp);
    bit ok;
    logic [4:0] exp_idx;
    bus.DOUT_READY_i = 1'b0;
    offer(din, dec, ok);
    if (!ok) return;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      if (n == 0) chk({nm, "_busy_ready"}, 128'({bus.BUSY_o, bus.DIN_READY_o}), 128'(2'b10));
      if (n % 2 == 0) begin
        exp_idx = eff_dec(dec) ? 5'(31 - n/2) : 5'(n/2);
        chk($sformatf("%s_rkidx_r%0d", nm, n/2), 128'(bus.RK_IDX_o), 128'(exp_idx));
      end
      if (n == 63) chk({nm, "_valid_early"}, 128'(bus.DOUT_VALID_o), 128'(1'b0));
    end
    @(negedge clk);
    chk({nm, "_valid_at64"}, 128'(bus.DOUT_VALID_o), 128'(1'b1));
    chk({nm, "_dout"}, bus.DOUT_o, exp);
    for (int i = 0; i < bp; i++) begin
      @(posedge clk); #1;
      bus.DIN_VALID_i = 1'($urandom);
      bus.DIN_i       = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      chk($sformatf("%s_bp_dout_c%0d", nm, i), bus.DOUT_o, exp);
      chk($sformatf("%s_bp_flags_c%0d", nm, i),
          128'({bus.DOUT_VALID_o, bus.DIN_READY_o, bus.BUSY_o}), 128'(3'b101));
    end
    @(posedge clk); #1;
    bus.DIN_VALID_i  = 1'b0;
    bus.DOUT_READY_i = 1'b1;
    @(posedge clk); #1;
    bus.DOUT_READY_i = 1'b0;
    @(negedge clk);
    chk({nm, "_post_hs"}, 128'({bus.DOUT_VALID_o, bus.DIN_READY_o, bus.BUSY_o}), 128'(3'b010));
  endtask

  typedef struct {
    string        nm;
    logic [127:0] key;
    logic [127:0] din;
    logic         dec;
    logic [127:0] exp;
    int           bp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    bus.DIN_VALID_i  = 1'b0;
    bus.DIN_i        = '0;
    bus.DEC_i        = 1'b0;
    bus.DOUT_READY_i = 1'b0;
    set_key(STD_KEY);

    vecs[0] = '{"std_enc", STD_KEY, STD_PT, 1'b0, STD_CT, 10};
`ifdef SM4_DEC_EN
    vecs[1] = '{"std_dec", STD_KEY, STD_CT, 1'b1, STD_PT, 0};
`else
    vecs[1] = '{"std_dec_ignored", STD_KEY, STD_PT, 1'b1, STD_CT, 0};
`endif
    for (int i = 2; i < 6; i++) begin
      vecs[i].nm  = $sformatf("rand%0d", i);
      vecs[i].key = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].din = {$urandom, $urandom, $urandom, $urandom};
      vecs[i].dec = 1'($urandom);
      vecs[i].bp  = int'($urandom_range(0, 3));
      set_key(vecs[i].key);
      vecs[i].exp = model(vecs[i].din, eff_dec(vecs[i].dec));
    end

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      set_key(vecs[i].key);
      run_block(vecs[i].nm, vecs[i].din, vecs[i].dec, vecs[i].exp, vecs[i].bp);
    end

    // Back-to-back: VALID held high, second block accepted 66 cycles after the first.
    begin
      logic [127:0] din_b, exp_b;
      logic [127:0] res [2];
      int acc [2];
      int na, no;
      set_key(STD_KEY);
      din_b = {$urandom, $urandom, $urandom, $urandom};
      exp_b = model(din_b, 1'b0);
      na = 0; no = 0;
      @(posedge clk); #1;
      bus.DIN_VALID_i  = 1'b1;
      bus.DIN_i        = STD_PT;
      bus.DEC_i        = 1'b0;
      bus.DOUT_READY_i = 1'b1;
      for (int c = 0; c < 300 && no < 2; c++) begin
        @(negedge clk);
        if (bus.DIN_VALID_i && bus.DIN_READY_o && na < 2) begin acc[na] = c; na++; end
        if (bus.DOUT_VALID_o && bus.DOUT_READY_i) begin res[no] = bus.DOUT_o; no++; end
        @(posedge clk); #1;
        if (na == 1) bus.DIN_i = din_b;
        if (na == 2) bus.DIN_VALID_i = 1'b0;
      end
      bus.DIN_VALID_i  = 1'b0;
      bus.DOUT_READY_i = 1'b0;
      chk("b2b_outputs", 128'(no), 128'(2));
      if (na == 2) chk("b2b_period", 128'(acc[1] - acc[0]), 128'(66));
      else chk("b2b_accepts", 128'(na), 128'(2));
      if (no == 2) begin
        chk("b2b_dout0", res[0], STD_CT);
        chk("b2b_dout1", res[1], exp_b);
      end
    end

    // Reset asserted during round 15's SUB cycle aborts the block.
    begin
      bit ok;
      set_key(STD_KEY);
      offer(STD_PT, 1'b0, ok);
      if (ok) begin
        for (int n = 0; n <= 30; n++) @(negedge clk);
        chk("abort_rkidx_r15", 128'(bus.RK_IDX_o), 128'(15));
        #1 rst = 1'b1;
        #1 chk_reset_vals("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (70) @(negedge clk);
        chk("abort_no_output", 128'(bus.DOUT_VALID_o), 128'(1'b0));
      end
      run_block("after_abort", STD_PT, 1'b0, STD_CT, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
